// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared memory-bus definitions for the instruction/data arbiter.
//   - bus_cmd_e   : 2-bit bus command encodings (BUS_NONE/BUS_LOAD/BUS_STORE)
//   - mem_owner_e : owner of an outstanding load tag (I-side or D-side)
//   - MEM_TAG_W   : width of memory transaction tags (tag 0 means "none")
package mem_arb_pkg;

  localparam int MEM_TAG_W    = 4;
  localparam int MEM_ADDR_W   = 64;
  localparam int MEM_DATA_W   = 64;
  localparam int MEM_NUM_TAGS = 1 << MEM_TAG_W;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } mem_owner_e;

endpackage

// File: rtl/mem_tag_table.sv
// mem_tag_table: records which client owns each outstanding memory load tag.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears all entries)
//   alloc_en      allocate alloc_tag to alloc_owner at the next posedge
//   alloc_tag     tag being allocated (tag 0 is never stored)
//   alloc_owner   client that issued the load
//   lookup_tag    tag currently returning from memory (0 = no return)
//   lookup_vld    returning tag is outstanding; the entry retires at next posedge
//   lookup_owner  owner of the returning tag (meaningful only with lookup_vld)
//   err           this cycle saw a return of an unknown tag or an allocation
//                 over a live entry
module mem_tag_table
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  mem_owner_e           alloc_owner,
  input  logic [MEM_TAG_W-1:0] lookup_tag,
  output logic                 lookup_vld,
  output mem_owner_e           lookup_owner,
  output logic                 err
);

  logic [MEM_NUM_TAGS-1:0] vld;
  mem_owner_e              own [MEM_NUM_TAGS];

  logic lookup_hit;
  logic alloc_do;
  logic alloc_clash;

  assign lookup_hit   = (lookup_tag != '0);
  assign lookup_vld   = lookup_hit && vld[lookup_tag];
  assign lookup_owner = own[lookup_tag];
  assign alloc_do     = alloc_en && (alloc_tag != '0);

  // An entry that retires in the same cycle it is reallocated is a legal
  // handover, not an overwrite of a live transaction.
  assign alloc_clash  = alloc_do && vld[alloc_tag] &&
                        !(lookup_vld && (lookup_tag == alloc_tag));
  assign err          = (lookup_hit && !vld[lookup_tag]) || alloc_clash;

  // Valid bits: retire first, then allocate, so allocation wins on a shared tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      if (lookup_vld) vld[lookup_tag] <= 1'b0;
      if (alloc_do)   vld[alloc_tag]  <= 1'b1;
    end
  end

  // Owner bits are qualified by vld and need no reset.
  always_ff @(posedge clk) begin
    if (alloc_do) own[alloc_tag] <= alloc_owner;
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: arbitrates the I-side and D-side caches onto a single memory bus.
// D-side has priority; memory accept tags go straight back to the granted
// client and returning data is routed by the owner recorded in mem_tag_table.
// Optional feature: define MEM_ARB_FAIR_EN to add an I-side starvation
// counter that forces one I-side grant after STARVE_LIMIT denied cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Ictrl2mem_*              I-side request (addr, command: NONE/LOAD)
//   mem2Ictrl_*              I-side accept tag, return tag and return data
//   Dctrl2mem_*              D-side request (addr, store data, command)
//   mem2Dctrl_*              D-side accept tag, return tag and return data
//   proc2mem_*               request forwarded to memory
//   mem2proc_*               memory accept tag, return tag and return data
//   arb_err_o                sticky: unknown return tag or tag overwrite seen
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_ADDR_W-1:0] Ictrl2mem_addr_i,
  input  logic [1:0]            Ictrl2mem_command_i,
  output logic [MEM_TAG_W-1:0]  mem2Ictrl_response_o,
  output logic [MEM_TAG_W-1:0]  mem2Ictrl_tag_o,
  output logic [MEM_DATA_W-1:0] mem2Ictrl_data_o,
  input  logic [MEM_ADDR_W-1:0] Dctrl2mem_addr_i,
  input  logic [MEM_DATA_W-1:0] Dctrl2mem_data_i,
  input  logic [1:0]            Dctrl2mem_command_i,
  output logic [MEM_TAG_W-1:0]  mem2Dctrl_response_o,
  output logic [MEM_TAG_W-1:0]  mem2Dctrl_tag_o,
  output logic [MEM_DATA_W-1:0] mem2Dctrl_data_o,
  output logic [MEM_ADDR_W-1:0] proc2mem_addr_o,
  output logic [MEM_DATA_W-1:0] proc2mem_data_o,
  output logic [1:0]            proc2mem_command_o,
  input  logic [MEM_TAG_W-1:0]  mem2proc_response_i,
  input  logic [MEM_TAG_W-1:0]  mem2proc_tag_i,
  input  logic [MEM_DATA_W-1:0] mem2proc_data_i,
  output logic                  arb_err_o
);

  logic       i_req;
  logic       d_req;
  logic       grant_i;
  logic       grant_d;
  logic       force_i;
  logic       accepted;
  logic       alloc_en;
  mem_owner_e alloc_owner;
  logic       lookup_vld;
  mem_owner_e lookup_owner;
  logic       tbl_err;
  logic       ret_i;
  logic       ret_d;

  assign i_req    = (Ictrl2mem_command_i != BUS_NONE);
  assign d_req    = (Dctrl2mem_command_i != BUS_NONE);
  assign grant_i  = i_req && (force_i || !d_req);
  assign grant_d  = d_req && !grant_i;
  assign accepted = (mem2proc_response_i != '0);

  always_comb begin
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    proc2mem_command_o = BUS_NONE;
    if (grant_d) begin
      proc2mem_addr_o    = Dctrl2mem_addr_i;
      proc2mem_data_o    = Dctrl2mem_data_i;
      proc2mem_command_o = Dctrl2mem_command_i;
    end else if (grant_i) begin
      proc2mem_addr_o    = Ictrl2mem_addr_i;
      proc2mem_command_o = Ictrl2mem_command_i;
    end
  end

  assign mem2Ictrl_response_o = grant_i ? mem2proc_response_i : '0;
  assign mem2Dctrl_response_o = grant_d ? mem2proc_response_i : '0;

  // Only accepted loads expect data back; stores leave no table entry.
  assign alloc_en    = accepted &&
                       ((grant_i && (Ictrl2mem_command_i == BUS_LOAD)) ||
                        (grant_d && (Dctrl2mem_command_i == BUS_LOAD)));
  assign alloc_owner = grant_d ? OWNER_D : OWNER_I;

  mem_tag_table u_tag_table (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (alloc_en),
    .alloc_tag    (mem2proc_response_i),
    .alloc_owner  (alloc_owner),
    .lookup_tag   (mem2proc_tag_i),
    .lookup_vld   (lookup_vld),
    .lookup_owner (lookup_owner),
    .err          (tbl_err)
  );

  assign ret_i = lookup_vld && (lookup_owner == OWNER_I);
  assign ret_d = lookup_vld && (lookup_owner == OWNER_D);

  assign mem2Ictrl_tag_o  = ret_i ? mem2proc_tag_i  : '0;
  assign mem2Ictrl_data_o = ret_i ? mem2proc_data_i : '0;
  assign mem2Dctrl_tag_o  = ret_d ? mem2proc_tag_i  : '0;
  assign mem2Dctrl_data_o = ret_d ? mem2proc_data_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_err_o <= 1'b0;
    end else if (tbl_err) begin
      arb_err_o <= 1'b1;
    end
  end

`ifdef MEM_ARB_FAIR_EN
  logic [3:0] starve_cnt;
  logic [4:0] starve_inc;

  assign starve_inc = {1'b0, starve_cnt} + 5'd1;

  // Counts consecutive I-side cycles without an accept; hitting the limit
  // grants the I-side unconditionally for one cycle and restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      force_i    <= 1'b0;
    end else begin
      force_i <= 1'b0;
      if (i_req) begin
        if (grant_i && accepted) begin
          starve_cnt <= '0;
        end else if (starve_inc == 5'(STARVE_LIMIT)) begin
          starve_cnt <= '0;
          force_i    <= 1'b1;
        end else begin
          starve_cnt <= starve_inc[3:0];
        end
      end
    end
  end
`else
  assign force_i = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scenarios with literal expectations, followed by a
// randomized run; every cycle the DUT outputs are compared against a
// behavioural model of grants, the tag-owner map and the error flag.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_addr;
  logic [1:0]  i_cmd;
  logic [3:0]  i_resp, i_tag;
  logic [63:0] i_data;
  logic [63:0] d_addr, d_wdata;
  logic [1:0]  d_cmd;
  logic [3:0]  d_resp, d_tag;
  logic [63:0] d_data;
  logic [63:0] p_addr, p_data;
  logic [1:0]  p_cmd;
  logic [3:0]  m_resp, m_tag;
  logic [63:0] m_data;
  logic        err;

  mem_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .Ictrl2mem_addr_i     (i_addr),
    .Ictrl2mem_command_i  (i_cmd),
    .mem2Ictrl_response_o (i_resp),
    .mem2Ictrl_tag_o      (i_tag),
    .mem2Ictrl_data_o     (i_data),
    .Dctrl2mem_addr_i     (d_addr),
    .Dctrl2mem_data_i     (d_wdata),
    .Dctrl2mem_command_i  (d_cmd),
    .mem2Dctrl_response_o (d_resp),
    .mem2Dctrl_tag_o      (d_tag),
    .mem2Dctrl_data_o     (d_data),
    .proc2mem_addr_o      (p_addr),
    .proc2mem_data_o      (p_data),
    .proc2mem_command_o   (p_cmd),
    .mem2proc_response_i  (m_resp),
    .mem2proc_tag_i       (m_tag),
    .mem2proc_data_i      (m_data),
    .arb_err_o            (err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Model state: owner per tag (-1 = not outstanding, 0 = I, 1 = D).
  int owner_of [16];
  bit m_err    = 1'b0;
  int m_starve = 0;
  bit m_force  = 1'b0;

  initial for (int t = 0; t < 16; t++) owner_of[t] = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle reference compare, then advance the model to the next cycle.
  always @(negedge clk) begin
    bit          ireq, dreq, gi, gd, alloc, nf;
    int          own;
    logic [63:0] e_addr, e_data;
    logic [1:0]  e_cmd;
    if (chk_en) begin
      ireq = (i_cmd != BUS_NONE);
      dreq = (d_cmd != BUS_NONE);
      gi   = ireq && (m_force || !dreq);
      gd   = dreq && !gi;
      e_addr = 0; e_data = 0; e_cmd = BUS_NONE;
      if (gd) begin e_addr = d_addr; e_data = d_wdata; e_cmd = d_cmd; end
      else if (gi) begin e_addr = i_addr; e_cmd = i_cmd; end
      own = (m_tag != 0) ? owner_of[m_tag] : -1;

      check("m_proc_addr", p_addr, e_addr);
      check("m_proc_data", p_data, e_data);
      check("m_proc_cmd", 64'(p_cmd), 64'(e_cmd));
      check("m_i_resp", 64'(i_resp), gi ? 64'(m_resp) : 64'd0);
      check("m_d_resp", 64'(d_resp), gd ? 64'(m_resp) : 64'd0);
      check("m_i_tag", 64'(i_tag), (own == 0) ? 64'(m_tag) : 64'd0);
      check("m_i_data", i_data, (own == 0) ? m_data : 64'd0);
      check("m_d_tag", 64'(d_tag), (own == 1) ? 64'(m_tag) : 64'd0);
      check("m_d_data", d_data, (own == 1) ? m_data : 64'd0);
      check("m_err", 64'(err), 64'(m_err));

      if (rst) begin
        for (int t = 0; t < 16; t++) owner_of[t] = -1;
        m_err = 0; m_starve = 0; m_force = 0;
      end else begin
        alloc = (m_resp != 0) && ((gi && i_cmd == BUS_LOAD) || (gd && d_cmd == BUS_LOAD));
        if (m_tag != 0 && own < 0) m_err = 1;
        if (alloc && owner_of[m_resp] >= 0 && !(own >= 0 && m_tag == m_resp)) m_err = 1;
        if (own >= 0) owner_of[m_tag] = -1;
        if (alloc) owner_of[m_resp] = gd ? 1 : 0;
        nf = 0;
`ifdef MEM_ARB_FAIR_EN
        if (ireq) begin
          if (gi && m_resp != 0) m_starve = 0;
          else begin
            m_starve++;
            if (m_starve == LIMIT) begin m_starve = 0; nf = 1; end
          end
        end
`endif
        m_force = nf;
      end
    end
  end

  // One bus cycle: drive inputs just after the edge, return mid-cycle so
  // literal expectations can be checked before the next edge.
  task automatic drive(input logic [1:0] ic, input logic [63:0] ia,
                       input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
                       input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] rd);
    @(posedge clk);
    #1;
    i_cmd = ic; i_addr = ia;
    d_cmd = dc; d_addr = da; d_wdata = dd;
    m_resp = rsp; m_tag = tg; m_data = rd;
    #2;
  endtask

  task automatic idle();
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    i_cmd = BUS_NONE; d_cmd = BUS_NONE; m_resp = 0; m_tag = 0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_cmd = BUS_NONE; i_addr = 0;
    d_cmd = BUS_NONE; d_addr = 0; d_wdata = 0;
    m_resp = 0; m_tag = 0; m_data = 0;
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #2;
    check("rst_i_resp", 64'(i_resp), 0);
    check("rst_d_resp", 64'(d_resp), 0);
    check("rst_i_tag", 64'(i_tag), 0);
    check("rst_d_tag", 64'(d_tag), 0);
    check("rst_err", 64'(err), 0);
    check("rst_cmd", 64'(p_cmd), 64'(BUS_NONE));

    // I-side load alone, then its data return.
    drive(BUS_LOAD, 64'h100, BUS_NONE, 0, 0, 4'd3, 0, 0);
    check("s1_i_resp", 64'(i_resp), 3);
    check("s1_addr", p_addr, 64'h100);
    check("s1_d_resp", 64'(d_resp), 0);
    idle();
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd3, 64'hDEAD);
    check("s1_i_tag", 64'(i_tag), 3);
    check("s1_i_data", i_data, 64'hDEAD);
    check("s1_d_tag", 64'(d_tag), 0);

    // Both load in one cycle: D wins.
    drive(BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 0, 4'd5, 0, 0);
    check("s2_d_resp", 64'(d_resp), 5);
    check("s2_i_resp", 64'(i_resp), 0);
    check("s2_addr", p_addr, 64'h300);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd5, 64'hBEEF);
    check("s2_d_tag", 64'(d_tag), 5);
    check("s2_d_data", d_data, 64'hBEEF);
    check("s2_i_tag", 64'(i_tag), 0);

    // Tag 4 retires to I while D reallocates it.
    drive(BUS_LOAD, 64'h440, BUS_NONE, 0, 0, 4'd4, 0, 0);
    drive(BUS_NONE, 0, BUS_LOAD, 64'h500, 0, 4'd4, 4'd4, 64'h1111);
    check("s4_i_tag", 64'(i_tag), 4);
    check("s4_i_data", i_data, 64'h1111);
    check("s4_d_resp", 64'(d_resp), 4);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd4, 64'h2222);
    check("s4_d_tag", 64'(d_tag), 4);
    check("s4_d_data", d_data, 64'h2222);
    check("s4_i_tag2", 64'(i_tag), 0);
    check("s4_err", 64'(err), 0);

    // Accepted store leaves no entry; its tag returning is an error.
    drive(BUS_NONE, 0, BUS_STORE, 64'h400, 64'h55, 4'd7, 0, 0);
    check("s3_d_resp", 64'(d_resp), 7);
    check("s3_cmd", 64'(p_cmd), 64'(BUS_STORE));
    check("s3_wdata", p_data, 64'h55);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd7, 64'h77);
    check("s3_i_tag", 64'(i_tag), 0);
    check("s3_d_tag", 64'(d_tag), 0);
    idle();
    check("s3_err", 64'(err), 1);

    // Tags outstanding across reset are forgotten.
    drive(BUS_LOAD, 64'h20, BUS_NONE, 0, 0, 4'd2, 0, 0);
    drive(BUS_NONE, 0, BUS_LOAD, 64'h90, 0, 4'd9, 0, 0);
    pulse_reset();
    #2;
    check("s6_err_clr", 64'(err), 0);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd2, 64'h22);
    check("s6_i_tag", 64'(i_tag), 0);
    check("s6_d_tag", 64'(d_tag), 0);
    idle();
    check("s6_err", 64'(err), 1);

    // Continuous contention: fairness forces the I-side on cycle 4.
    pulse_reset();
    for (int c = 1; c <= 5; c++) begin
      drive(BUS_LOAD, 64'h1000, BUS_LOAD, 64'h2000, 0, 4'(c), 0, 0);
`ifdef MEM_ARB_FAIR_EN
      check($sformatf("s5_i_resp_c%0d", c), 64'(i_resp), (c == 4) ? 64'(c) : 64'd0);
      check($sformatf("s5_d_resp_c%0d", c), 64'(d_resp), (c == 4) ? 64'd0 : 64'(c));
`else
      check($sformatf("s5_i_resp_c%0d", c), 64'(i_resp), 0);
      check($sformatf("s5_d_resp_c%0d", c), 64'(d_resp), 64'(c));
`endif
    end
    idle();

    // Randomized traffic; the per-cycle model compare does the checking.
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] ic, dc;
      logic [3:0] rsp, tg;
      ic  = ($urandom_range(0, 2) != 0) ? BUS_LOAD : BUS_NONE;
      dc  = 2'($urandom_range(0, 2));
      rsp = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
      tg  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      @(posedge clk); #1;
      rst = ($urandom_range(0, 149) == 0);
      i_cmd = ic; i_addr = {$urandom, $urandom};
      d_cmd = dc; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
      m_resp = rsp; m_tag = tg; m_data = {$urandom, $urandom};
    end
    @(posedge clk); #1 rst = 1'b0;
    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: number of consecutive denied I-side cycles before the I-side is forced to win (range 1..15).
REQ-002 SHALL have ports, clock and reset first:
 clk  in  1  sole clock; all state updates on posedge.
 rst  in  1  synchronous, active-high reset.
 Ictrl2mem_addr_i  in  64  I-side request address.
 Ictrl2mem_command_i  in  2  I-side command; only BUS_NONE or BUS_LOAD is legal.
 mem2Ictrl_response_o  out  4  I-side accept tag; 0 means not accepted.
 mem2Ictrl_tag_o  out  4  I-side data-return tag; 0 means none.
 mem2Ictrl_data_o  out  64  I-side return data.
 Dctrl2mem_addr_i  in  64  D-side request address.
 Dctrl2mem_data_i  in  64  D-side store data.
 Dctrl2mem_command_i  in  2  D-side command: BUS_NONE, BUS_LOAD or BUS_STORE.
 mem2Dctrl_response_o  out  4  D-side accept tag.
 mem2Dctrl_tag_o  out  4  D-side data-return tag.
 mem2Dctrl_data_o  out  64  D-side return data.
 proc2mem_addr_o  out  64  address to memory.
 proc2mem_data_o  out  64  store data to memory.
 proc2mem_command_o  out  2  command to memory.
 mem2proc_response_i  in  4  memory accept tag; 0 means rejected.
 mem2proc_tag_i  in  4  memory data-return tag.
 mem2proc_data_i  in  64  memory return data.
 arb_err_o  out  1  sticky error flag.

Function
REQ-003 Grant SHALL be combinational each cycle: D-side wins when its command is not BUS_NONE, unless force_i is set; otherwise I-side wins if its command is not BUS_NONE.
REQ-004 The granted client's addr, data and command SHALL drive proc2mem_*; with no grant, command SHALL be BUS_NONE and addr/data SHALL be 0.
REQ-005 mem2proc_response_i SHALL go, in the same cycle, only to the granted client's response output; the other client's response output SHALL be 0.
REQ-006 Owner table, tags 1..15, each entry a valid bit plus an owner bit (0=I, 1=D): a granted BUS_LOAD with a nonzero response SHALL set valid and owner for that tag at the next posedge.
REQ-007 An accepted BUS_STORE SHALL NOT allocate a table entry.
REQ-008 When mem2proc_tag_i is nonzero and its entry is valid, the tag and data SHALL go to the owner's tag/data outputs in that same cycle, and the entry SHALL clear at the next posedge; the non-owner's tag output SHALL be 0.
REQ-009 When mem2proc_tag_i is nonzero and its entry is invalid, the return SHALL be dropped (both tag outputs 0) and arb_err_o SHALL set.
REQ-010 If the same tag is retired and allocated in one cycle, allocation SHALL win and the entry SHALL end valid with the new owner.
REQ-011 If an allocation hits an already-valid entry, the entry SHALL be overwritten and arb_err_o SHALL set.
REQ-012 mem2*_data_o SHALL be 0 whenever the matching tag output is 0.
REQ-013 Request-to-response latency SHALL be 0 cycles; memory return-to-client latency SHALL be 0 cycles; the only state is the owner table, starvation counter, force_i and arb_err_o.

Reset
REQ-014 On rst, the owner table SHALL clear, the starvation counter, force_i and arb_err_o SHALL be 0, and the outputs SHALL follow REQ-004/005/008 from the cleared state, i.e. all response and tag outputs are 0 while inputs are idle.
REQ-015 Returns of tags issued before reset and arriving after it SHALL be treated as invalid (REQ-009).

Configuration
REQ-016 With macro MEM_ARB_FAIR_EN defined:
 - a 4-bit counter SHALL increment each cycle the I-side requests and is not granted or is rejected (response 0);
 - the counter SHALL reset to 0 on an I-side accept;
 - when the counter reaches STARVE_LIMIT, force_i SHALL set for exactly the next cycle and the counter SHALL clear.
REQ-017 Without MEM_ARB_FAIR_EN, arbitration SHALL be strict D-priority, force_i SHALL be constant 0, and the counter SHALL be absent.

Structure
REQ-018 BUS_NONE/BUS_LOAD/BUS_STORE encodings (2 bits) and MEM_TAG_W=4 SHALL come from the shared system package/defines; the owner encoding typedef SHALL live there too.
REQ-019 The owner table SHALL be the sub-module mem_tag_table (ports: alloc_en, alloc_tag, alloc_owner, lookup_tag, lookup_vld, lookup_owner, err); the rest stays in mem_arb.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
 - I LOAD 0x100 alone, response 3 -> mem2Ictrl_response_o=3, proc2mem_addr_o=0x100; later tag 3 with data 0xDEAD -> mem2Ictrl_tag_o=3, data 0xDEAD, mem2Dctrl_tag_o=0.
 - I and D both LOAD in one cycle, response 5 -> D granted, mem2Dctrl_response_o=5, mem2Ictrl_response_o=0; tag 5 returns to D only.
 - D STORE accepted with tag 7, then memory returns tag 7 -> dropped, arb_err_o=1.
 - Tag 4 retires (owner I) in the same cycle D allocates tag 4 -> I gets the data; the next return of tag 4 goes to D.
 - MEM_ARB_FAIR_EN, STARVE_LIMIT=3, D and I both requesting continuously -> I granted on cycle 4, D on cycles 1-3 and 5.
 - rst asserted with tags 2 and 9 outstanding, then tag 2 returns -> both tag outputs 0, arb_err_o=1.
